// File: rtl/mlp_pkg.sv
// Shared constants, state encoding, stream codes and strobe bundle for the MLP sequencer.
package mlp_pkg;

    // Network shape
    localparam int unsigned N_IN  = 784;
    localparam int unsigned N_HID = 30;
    localparam int unsigned N_OUT = 10;
    localparam int unsigned CHUNK = 16;

    // Port and counter widths
    localparam int unsigned ST_W   = 4;
    localparam int unsigned CNT_W  = 15;
    localparam int unsigned CNT1_W = 11;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ENT_W  = 7;
    localparam int unsigned STRM_W = 2;

    // Beat addressing: byte index advances by one word per accepted beat
    localparam int unsigned BEAT_BYTES  = 4;
    localparam int unsigned BIAS_LAST   = 40;
    localparam int unsigned CHUNK_LAST  = (CHUNK / 4 - 1) * BEAT_BYTES;
    localparam int unsigned W2_LAST     = 56;
    localparam int unsigned L1_MAC_LAST = 8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_BIAS  = 4'd1,
        ST_LOAD_CHUNK = 4'd2,
        ST_L1_MAC     = 4'd3,
        ST_L1_COMMIT  = 4'd4,
        ST_SIGMOID    = 4'd5,
        ST_LOAD_W2    = 4'd6,
        ST_L2_MAC     = 4'd7,
        ST_DONE       = 4'd8
    } state_e;

    typedef enum logic [STRM_W-1:0] {
        STREAM_BIAS  = 2'd0,
        STREAM_CHUNK = 2'd1,
        STREAM_W2    = 2'd2
    } stream_e;

    typedef struct packed {
        logic load_start;
        logic load_weight;
        logic layer1_start;
        logic layer2_start;
        logic sigmoid_start;
        logic read;
    } dp_strobe_t;

    // W2 bank entry: second neuron of a bank sits N_HID entries past the first;
    // the commit cycle (c21 = N_HID) holds the last valid entry.
    function automatic logic [ENT_W-1:0] l2_entry(input logic [IDX_W-1:0] c3,
                                                  input logic [IDX_W-1:0] c21);
        logic [IDX_W-1:0] par;
        logic [ENT_W-1:0] base;
        logic [ENT_W-1:0] off;
        par  = c3 & IDX_W'(1);
        base = (par != '0) ? ENT_W'(N_HID) : '0;
        off  = (c21 > IDX_W'(N_HID - 1)) ? ENT_W'(N_HID - 1) : ENT_W'(c21);
        return base + off;
    endfunction

endpackage

// File: rtl/mlp_seq_ctrl_if.sv
// Host request/status and operand stream handshake between sequencer and its environment.
interface mlp_seq_ctrl_if;
    import mlp_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              mem_valid;
    logic              mem_req;
    logic [STRM_W-1:0] mem_stream;

    modport master (
        input  start,
        input  mem_valid,
        output busy,
        output done,
        output mem_req,
        output mem_stream
    );

    modport slave (
        output start,
        output mem_valid,
        input  busy,
        input  done,
        input  mem_req,
        input  mem_stream
    );

endinterface

// File: rtl/mlp_beat_cnt.sv
// Stall-aware step-4 beat counter: next value and terminal detect for the load states.
module mlp_beat_cnt
    import mlp_pkg::*;
(
    input  logic [CNT_W-1:0] cnt,
    input  logic             active,
    input  logic             valid,
    input  logic [CNT_W-1:0] last,
    output logic             step_c,
    output logic             last_c,
    output logic [CNT_W-1:0] next_c
);

    // A beat is consumed only when a load state sees a valid word
    always_comb begin
        step_c = active & valid;
        last_c = step_c & (cnt == last);
        next_c = cnt + CNT_W'(BEAT_BYTES);
    end

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Phase sequencer for the 784-30-10 MLP MAC datapath.
module mlp_seq_ctrl
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mlp_seq_ctrl_if.master    bus,
    output logic [ST_W-1:0]   FSM_STATE,
    output logic              load_start,
    output logic              load_weight,
    output logic              layer1_start,
    output logic              layer2_start,
    output logic              sigmoid_start,
    output logic              read,
    output logic [CNT_W-1:0]  counter,
    output logic [CNT1_W-1:0] counter1,
    output logic [IDX_W-1:0]  counter2,
    output logic [IDX_W-1:0]  counter3,
    output logic [IDX_W-1:0]  counter2_1,
    output logic [ENT_W-1:0]  counter2_2
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [CNT1_W-1:0]   counter1_q, counter1_d;
    logic [IDX_W-1:0]    counter2_q, counter2_d;
    logic [IDX_W-1:0]    counter3_q, counter3_d;
    logic [IDX_W-1:0]    counter2_1_q, counter2_1_d;
    logic [ENT_W-1:0]    counter2_2_q, counter2_2_d;

    logic                mem_req_c;
    logic [CNT_W-1:0]    beat_term_c;
    logic                beat_step_c;
    logic                beat_last_c;
    logic [CNT_W-1:0]    beat_next_c;
    dp_strobe_t          strobe_c;
    stream_e             stream_c;

    // Load states request beats; terminal index depends on the stream being fetched
    always_comb begin
        mem_req_c   = (state_q == ST_LOAD_BIAS) || (state_q == ST_LOAD_CHUNK) ||
                      (state_q == ST_LOAD_W2);
        beat_term_c = CNT_W'(W2_LAST);
        case (state_q)
            ST_LOAD_BIAS:  beat_term_c = CNT_W'(BIAS_LAST);
            ST_LOAD_CHUNK: beat_term_c = CNT_W'(CHUNK_LAST);
            default:       beat_term_c = CNT_W'(W2_LAST);
        endcase
    end

    mlp_beat_cnt u_beat_cnt (
        .cnt    (counter_q),
        .active (mem_req_c),
        .valid  (bus.mem_valid),
        .last   (beat_term_c),
        .step_c (beat_step_c),
        .last_c (beat_last_c),
        .next_c (beat_next_c)
    );

    // Next-state, counter updates and datapath strobes
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        counter1_d   = counter1_q;
        counter2_d   = counter2_q;
        counter3_d   = counter3_q;
        counter2_1_d = counter2_1_q;
        counter2_2_d = '0;
        strobe_c     = '0;
        stream_c     = STREAM_BIAS;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD_BIAS;
                end
            end

            ST_LOAD_BIAS: begin
                strobe_c.load_start = beat_step_c;
                if (beat_last_c) begin
                    counter_d  = '0;
                    counter1_d = '0;
                    counter2_d = '0;
                    state_d    = ST_LOAD_CHUNK;
                end else if (beat_step_c) begin
                    counter_d = beat_next_c;
                end
            end

            ST_LOAD_CHUNK: begin
                stream_c            = STREAM_CHUNK;
                strobe_c.read       = 1'b1;
                strobe_c.load_start = beat_step_c;
                if (beat_last_c) begin
                    counter_d = '0;
                    state_d   = ST_L1_MAC;
                end else if (beat_step_c) begin
                    counter_d = beat_next_c;
                end
            end

            ST_L1_MAC: begin
                strobe_c.read         = 1'b1;
                strobe_c.layer1_start = 1'b1;
                if (counter_q == CNT_W'(L1_MAC_LAST)) begin
                    counter_d  = '0;
                    counter1_d = counter1_q + CNT1_W'(CHUNK);
                    state_d    = (counter1_d == CNT1_W'(N_IN)) ? ST_L1_COMMIT : ST_LOAD_CHUNK;
                end else begin
                    counter_d = CNT_W'(L1_MAC_LAST);
                end
            end

            ST_L1_COMMIT: begin
                strobe_c.read         = 1'b1;
                strobe_c.layer1_start = 1'b1;
                counter1_d            = '0;
                if (counter2_q == IDX_W'(N_HID - 1)) begin
                    counter2_d = '0;
                    state_d    = ST_SIGMOID;
                end else begin
                    counter2_d = counter2_q + IDX_W'(1);
                    state_d    = ST_LOAD_CHUNK;
                end
            end

            ST_SIGMOID: begin
                strobe_c.read          = 1'b1;
                strobe_c.sigmoid_start = 1'b1;
                if (counter2_q == IDX_W'(N_HID)) begin
                    counter2_d = '0;
                    counter3_d = '0;
                    state_d    = ST_LOAD_W2;
                end else begin
                    counter2_d = counter2_q + IDX_W'(1);
                end
            end

            ST_LOAD_W2: begin
                stream_c             = STREAM_W2;
                strobe_c.read        = 1'b1;
                strobe_c.load_weight = beat_step_c;
                if (beat_last_c) begin
                    counter_d    = '0;
                    counter2_1_d = '0;
                    state_d      = ST_L2_MAC;
                end else if (beat_step_c) begin
                    counter_d = beat_next_c;
                end
            end

            ST_L2_MAC: begin
                strobe_c.layer2_start = 1'b1;
                if (counter2_1_q == IDX_W'(N_HID)) begin
                    counter2_1_d = '0;
                    counter3_d   = counter3_q + IDX_W'(1);
                    if (counter3_d == IDX_W'(N_OUT)) begin
                        state_d = ST_DONE;
                    end else if (!counter3_d[0]) begin
                        state_d = ST_LOAD_W2;
                    end
                end else begin
                    counter2_1_d = counter2_1_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_L2_MAC) begin
            counter2_2_d = l2_entry(counter3_d, counter2_1_d);
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            counter1_q   <= '0;
            counter2_q   <= '0;
            counter3_q   <= '0;
            counter2_1_q <= '0;
            counter2_2_q <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            counter1_q   <= counter1_d;
            counter2_q   <= counter2_d;
            counter3_q   <= counter3_d;
            counter2_1_q <= counter2_1_d;
            counter2_2_q <= counter2_2_d;
        end
    end

    assign FSM_STATE      = state_q;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_stream = stream_c;
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign load_start     = strobe_c.load_start;
    assign load_weight    = strobe_c.load_weight;
    assign layer1_start   = strobe_c.layer1_start;
    assign layer2_start   = strobe_c.layer2_start;
    assign sigmoid_start  = strobe_c.sigmoid_start;
    assign read           = strobe_c.read;
    assign counter        = counter_q;
    assign counter1       = counter1_q;
    assign counter2       = counter2_q;
    assign counter3       = counter3_q;
    assign counter2_1     = counter2_1_q;
    assign counter2_2     = counter2_2_q;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Self-checking bench for mlp_seq_ctrl: vector table, hand sequences and a
// cycle-sequence reference built from the phase rules with nested loops.
module tb_mlp_seq_ctrl;
    import mlp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fsm_state;
    logic        load_start, load_weight, layer1_start, layer2_start, sigmoid_start, rd;
    logic [14:0] counter;
    logic [10:0] counter1;
    logic [4:0]  counter2, counter3, counter2_1;
    logic [6:0]  counter2_2;

    always #5 clk = ~clk;

    mlp_seq_ctrl_if bus();

    mlp_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .FSM_STATE     (fsm_state),
        .load_start    (load_start),
        .load_weight   (load_weight),
        .layer1_start  (layer1_start),
        .layer2_start  (layer2_start),
        .sigmoid_start (sigmoid_start),
        .read          (rd),
        .counter       (counter),
        .counter1      (counter1),
        .counter2      (counter2),
        .counter3      (counter3),
        .counter2_1    (counter2_1),
        .counter2_2    (counter2_2)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] cnt;
        logic [10:0] c1;
        logic [4:0]  c2;
        logic [4:0]  c3;
        logic [4:0]  c21;
        logic [6:0]  c22;
        logic        req;
        logic [1:0]  strm;
        logic        ls, lw, l1, l2, sg, rd, busy, done;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic load;
    } ev_t;

    typedef struct {
        logic start;
        logic valid;
        int   st;
        int   cnt;
        logic ls;
        logic busy;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_c3     = 0;
    ev_t  q[$];
    int   s_bias_ls, s_done, s_l2_commit, s_sig, s_w2, s_l1_commit;

    function automatic obs_t mk(input int st, input int cnt, input int c1, input int c2,
                                input int c3, input int c21, input int c22);
        obs_t o;
        o      = '0;
        o.st   = 4'(st);
        o.cnt  = 15'(cnt);
        o.c1   = 11'(c1);
        o.c2   = 5'(c2);
        o.c3   = 5'(c3);
        o.c21  = 5'(c21);
        o.c22  = 7'(c22);
        o.busy = (st != 0) && (st != 8);
        o.req  = (st == 1) || (st == 2) || (st == 6);
        o.strm = (st == 2) ? 2'd1 : (st == 6) ? 2'd2 : 2'd0;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = fsm_state;   o.cnt = counter;     o.c1 = counter1;    o.c2 = counter2;
        o.c3 = counter3;    o.c21 = counter2_1;  o.c22 = counter2_2;
        o.req = bus.mem_req; o.strm = bus.mem_stream;
        o.ls = load_start;  o.lw = load_weight;  o.l1 = layer1_start; o.l2 = layer2_start;
        o.sg = sigmoid_start; o.rd = rd; o.busy = bus.busy; o.done = bus.done;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d cnt=%0d c1=%0d c2=%0d c3=%0d c21=%0d c22=%0d req=%0b strm=%0d ls=%0b lw=%0b l1=%0b l2=%0b sg=%0b rd=%0b busy=%0b done=%0b",
                         o.st, o.cnt, o.c1, o.c2, o.c3, o.c21, o.c22, o.req, o.strm,
                         o.ls, o.lw, o.l1, o.l2, o.sg, o.rd, o.busy, o.done);
    endfunction

    // Fields the phase rules leave open outside their phase are not compared
    task automatic check_obs(input string name, input obs_t exp_i, input obs_t act_i, input int step);
        obs_t e, a;
        e = exp_i;
        a = act_i;
        if (e.st != 4'd7) begin e.c22 = '0; a.c22 = '0; end
        if (!(e.st inside {4'd1, 4'd2, 4'd7})) begin e.rd = 1'b0; a.rd = 1'b0; end
        if (!e.req) begin e.strm = '0; a.strm = '0; end
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s step %0d: got %s | required %s", name, step, fmt(act_i), fmt(exp_i));
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Expected cycle sequence of one full inference with every beat accepted
    task automatic build_run(input int c3_in);
        ev_t e;
        q.delete();
        for (int b = 0; b < 11; b++) begin
            e.o = mk(1, 4 * b, 0, 0, c3_in, 0, 0); e.o.ls = 1'b1; e.load = 1'b1; q.push_back(e);
        end
        for (int n = 0; n < int'(N_HID); n++) begin
            for (int k = 0; k < int'(N_IN / CHUNK); k++) begin
                for (int b = 0; b < int'(CHUNK / 4); b++) begin
                    e.o = mk(2, 4 * b, k * int'(CHUNK), n, c3_in, 0, 0);
                    e.o.ls = 1'b1; e.o.rd = 1'b1; e.load = 1'b1; q.push_back(e);
                end
                for (int m = 0; m < 2; m++) begin
                    e.o = mk(3, 8 * m, k * int'(CHUNK), n, c3_in, 0, 0);
                    e.o.l1 = 1'b1; e.load = 1'b0; q.push_back(e);
                end
            end
            e.o = mk(4, 0, int'(N_IN), n, c3_in, 0, 0); e.o.l1 = 1'b1; e.load = 1'b0; q.push_back(e);
        end
        for (int i = 0; i <= int'(N_HID); i++) begin
            e.o = mk(5, 0, 0, i, c3_in, 0, 0); e.o.sg = 1'b1; e.load = 1'b0; q.push_back(e);
        end
        for (int bank = 0; bank < int'(N_OUT / 2); bank++) begin
            for (int b = 0; b < 15; b++) begin
                e.o = mk(6, 4 * b, 0, 0, 2 * bank, 0, 0); e.o.lw = 1'b1; e.load = 1'b1; q.push_back(e);
            end
            for (int j = 0; j < 2; j++) begin
                for (int t = 0; t <= int'(N_HID); t++) begin
                    e.o = mk(7, 0, 0, 0, 2 * bank + j, t, 30 * j + ((t > 29) ? 29 : t));
                    e.o.l2 = 1'b1; e.load = 1'b0; q.push_back(e);
                end
            end
        end
        e.o = mk(8, 0, 0, 0, int'(N_OUT), 0, 0); e.o.done = 1'b1; e.load = 1'b0; q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b0; bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One inference from IDLE; stalled load cycles hold the expected step
    task automatic do_run(input string name, input int vpct, input bit hold);
        int   idx, iter, f0;
        bit   bad;
        obs_t exp_o, act_o;
        ev_t  e;
        build_run(m_c3);
        f0 = n_fail; bad = 1'b0;
        s_bias_ls = 0; s_done = 0; s_l2_commit = 0; s_sig = 0; s_w2 = 0; s_l1_commit = 0;
        bus.start = 1'b1; bus.mem_valid = 1'($urandom_range(1));
        @(negedge clk);
        check_obs({name, "_idle"}, mk(0, 0, 0, 0, m_c3, 0, 0), sample(), 0);
        @(posedge clk); #1;
        idx = 0; iter = 0;
        while (idx < q.size()) begin
            if (iter > 10 * q.size()) begin
                n_checks++; n_fail++; bad = 1'b1;
                $display("FAIL %s_timeout: reached step %0d, required %0d", name, idx, q.size());
                break;
            end
            if (n_fail - f0 > 20) begin
                bad = 1'b1;
                $display("%s aborted after repeated errors", name);
                break;
            end
            bus.mem_valid = ($urandom_range(99) < vpct);
            bus.start     = hold ? 1'b1 : 1'($urandom_range(1));
            @(negedge clk);
            e = q[idx];
            exp_o = e.o;
            if (e.load && !bus.mem_valid) begin
                exp_o.ls = 1'b0; exp_o.lw = 1'b0;
            end else begin
                idx++;
            end
            act_o = sample();
            check_obs(name, exp_o, act_o, idx);
            if (act_o.st == 4'd1 && act_o.ls) s_bias_ls++;
            if (act_o.done) s_done++;
            if (act_o.st == 4'd7 && act_o.c21 == 5'd30) s_l2_commit++;
            if (act_o.st == 4'd5) s_sig++;
            if (act_o.lw) s_w2++;
            if (act_o.st == 4'd4) s_l1_commit++;
            @(posedge clk); #1;
            iter++;
        end
        if (bad) begin
            do_reset();
            m_c3 = 0;
        end else begin
            m_c3 = int'(N_OUT);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int   pat[5];
        int   ecnt[5];
        bit   found;

        tbl[0] = '{1'b0, 1'b1, 0, 0,  1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 0, 0,  1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1, 0,  1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1, 0,  1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1, 4,  1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1, 8,  1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1, 8,  1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1, 8,  1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1, 12, 1'b0, 1'b1};

        rst = 1'b1; bus.start = 1'b0; bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_obs("reset", mk(0, 0, 0, 0, 0, 0, 0), sample(), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Start handshake and bias-beat stalls
        for (int i = 0; i < 9; i++) begin
            bus.start = tbl[i].start; bus.mem_valid = tbl[i].valid;
            @(negedge clk);
            n_checks++;
            if (fsm_state !== 4'(tbl[i].st) || counter !== 15'(tbl[i].cnt) ||
                load_start !== tbl[i].ls || bus.busy !== tbl[i].busy) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d cnt=%0d ls=%0b busy=%0b required st=%0d cnt=%0d ls=%0b busy=%0b",
                         i, fsm_state, counter, load_start, bus.busy,
                         tbl[i].st, tbl[i].cnt, tbl[i].ls, tbl[i].busy);
            end
            @(posedge clk); #1;
        end

        // Reset taken while in L1_MAC aborts at once
        bus.start = 1'b0; bus.mem_valid = 1'b1; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fsm_state == 4'd3) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_int("reach_l1_mac", int'(found), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_valid = 1'b1;
        @(negedge clk);
        check_obs("reset_mid_l1", mk(0, 0, 0, 0, 0, 0, 0), sample(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_obs("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0), sample(), 1);
        @(posedge clk); #1;
        m_c3 = 0;

        // Full run, all beats valid, random start pulses while busy
        do_run("run_full", 100, 1'b0);
        check_int("bias_beats", s_bias_ls, 11);
        check_int("l1_commits", s_l1_commit, int'(N_HID));
        check_int("sigmoid_cycles", s_sig, int'(N_HID) + 1);
        check_int("w2_beats", s_w2, 75);
        check_int("l2_commits", s_l2_commit, int'(N_OUT));
        check_int("done_pulses", s_done, 1);

        // Random stalls with start held, then back-to-back run
        do_run("run_stall", 70, 1'b1);
        check_int("done_pulses_stall", s_done, 1);
        do_run("run_b2b", 100, 1'b1);

        // W2 bank fetch with valid toggling 1,0,0,1
        bus.start = 1'b1; bus.mem_valid = 1'b1; found = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (fsm_state == 4'd6) begin found = 1'b1; break; end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check_int("reach_load_w2", int'(found), 1);
        check_int("w2_first_cnt", int'(counter), 0);
        check_int("w2_first_lw", int'(load_weight), 1);
        pat  = '{1, 0, 0, 1, 0};
        ecnt = '{4, 8, 8, 8, 12};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.mem_valid = 1'(pat[i]);
            @(negedge clk);
            n_checks++;
            if (fsm_state !== 4'd6 || counter !== 15'(ecnt[i]) || load_weight !== 1'(pat[i])) begin
                n_fail++;
                $display("FAIL w2_toggle%0d: got st=%0d cnt=%0d lw=%0b required st=6 cnt=%0d lw=%0d",
                         i, fsm_state, counter, load_weight, ecnt[i], pat[i]);
            end
        end
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check_obs("final_reset", mk(0, 0, 0, 0, 0, 0, 0), sample(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mlp_seq_ctrl.md
Name: mlp_seq_ctrl

Overview:
- Sequencer for the MLP MAC datapath (784-30-10 network).
- Drives the datapath's phase strobes and index counters: bias load, layer-1 chunked MAC over 30 hidden neurons, sigmoid write-back, and layer-2 MAC over 10 outputs in five W2 banks of 2 neurons.
- Fetches operands through a valid-qualified stream interface; reports busy/done to the host.

Parameters:
- N_IN, 784, layer-1 inputs per neuron (multiple of CHUNK)
- N_HID, 30, hidden neurons
- N_OUT, 10, output neurons (multiple of 2)
- CHUNK, 16, img/W1 entries held per chunk

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  host request; sampled only in IDLE
- mem_valid  input  1  din_a/din_w1/din_w2 beat valid this cycle
- mem_req  output  1  beat requested; high in load states
- mem_stream  output  2  stream selector: 0 bias, 1 img+W1 chunk, 2 W2 bank
- FSM_STATE  output  4  state encoding below
- load_start, load_weight, layer1_start, layer2_start, sigmoid_start, read  output  1 each  datapath strobes
- counter  output  15  beat byte index (step 4)
- counter1  output  11  layer-1 input offset
- counter2  output  5  hidden-neuron index
- counter3  output  5  output-neuron index
- counter2_1  output  5  layer-2 hidden index
- counter2_2  output  7  W2 bank entry index
- busy  output  1  high outside IDLE/DONE
- done  output  1  one-cycle pulse on entering DONE

Behaviour:
- Reset: state IDLE (0); all counters 0; all strobes, mem_req, busy, done 0. Reset mid-run aborts immediately with no drain.
- States: IDLE=0, LOAD_BIAS=1, LOAD_CHUNK=2, L1_MAC=3, L1_COMMIT=4, SIGMOID=5, LOAD_W2=6, L2_MAC=7, DONE=8.
- Load-state stall rule: in every load state, counter advances by 4 only when mem_valid=1, and load_start/load_weight are asserted only in that same cycle. With mem_valid=0, all counters and the state hold.
- IDLE: when start=1, go to LOAD_BIAS.
- LOAD_BIAS:
  - mem_stream=0; read=0; beats at counter 0,4,...,40 (11 beats; B1 uses 0..28, B2 uses 32..40).
  - After the beat at counter=40: counter←0, counter1←0, counter2←0, go to LOAD_CHUNK.
- LOAD_CHUNK:
  - mem_stream=1; read=1 (suppresses bias writes); load_start on valid beats; counter 0,4,8,12.
  - After the beat at 12: counter←0, go to L1_MAC.
- L1_MAC:
  - layer1_start=1 for 2 cycles, with counter=0 then 8.
  - Then counter1 += CHUNK. If the new counter1 = N_IN, go to L1_COMMIT; otherwise go to LOAD_CHUNK.
- L1_COMMIT:
  - One cycle; layer1_start=1, counter1=784 (datapath stores the neuron result).
  - Then counter1←0. If counter2 = N_HID-1: counter2←0, go to SIGMOID. Otherwise counter2++, go to LOAD_CHUNK.
- SIGMOID:
  - sigmoid_start=1; counter2 sweeps 0..N_HID (31 cycles; write-back lags by one index).
  - Then counter2←0, counter3←0, go to LOAD_W2.
- LOAD_W2:
  - mem_stream=2; load_weight on valid beats; counter 0..56 step 4 (15 beats).
  - Then counter←0, counter2_1←0, counter2_2←0, go to L2_MAC.
- L2_MAC:
  - layer2_start=1; read=0; counter2_1 counts 0..30.
  - counter2_2 = (counter3 mod 2)*30 + min(counter2_1,29).
  - At counter2_1=30 (commit cycle): counter2_1←0, counter3++.
  - If the new counter3 = N_OUT, go to DONE. Else if the new counter3 is even, go to LOAD_W2. Otherwise stay in L2_MAC.
- DONE: done=1 for one cycle, then IDLE. start is ignored outside IDLE.
- Counter widths: all counter arithmetic is unsigned and must never wrap within its declared width.

Decomposition:
- Shared package mlp_pkg holds the state enumeration (4-bit), stream-select codes, and network constants N_IN/N_HID/N_OUT/CHUNK, so the datapath and bench share them.
- One natural sub-module: mlp_beat_cnt, a stall-aware step-4 beat counter with terminal-value compare, reused by the three load states.

Test Plan:
- Reset mid-L1_MAC (rst=1 for 1 cycle) → next cycle FSM_STATE=0, all counters 0, busy=0, no strobes.
- start with mem_valid=1 throughout → exactly 11 load_start beats in LOAD_BIAS (counter 0..40); first LOAD_CHUNK cycle has read=1, counter=0.
- Full run with mem_valid=1:
  - Each hidden neuron takes 295 cycles (49×(4+2)+1), with counter1=784 only in the commit cycle.
  - SIGMOID lasts 31 cycles.
  - 5 LOAD_W2 phases of 15 beats each.
  - 10 L2 commits (counter2_1=30 with counter3=0..9).
  - done pulses exactly once, then FSM_STATE=0.
- mem_valid toggling 1,0,0,1 in LOAD_W2 → counter steps only on valid cycles; load_weight is never high while mem_valid=0.
- start held high continuously → after DONE the next run starts exactly one cycle after returning to IDLE; a start pulse during busy has no effect.
- Check counter2_2 during the second L2 neuron of a bank (counter3 odd) → 30..59, held at 59 during the counter2_1=30 cycle.
